// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode bus: IFU push handshake, decode pop handshake, redirect controls
// and the occupancy count. slave = the buffer, master = the environment driving it.
interface if_id_buffer_if;
  logic [31:0] F_Instr;
  logic [31:0] F_PC_plus_4;
  logic        F_Valid;
  logic        F_Ready;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic [31:0] D_PC_plus_4;
  logic        D_Valid;
  logic        D_Ready;
  logic        Flush;
  logic        KeepSlot;
  logic [1:0]  Count;

  // Both sides use valid/ready: a word moves only in a cycle where valid and
  // ready are high together at the rising edge; valid never depends on ready.
  modport slave (
    input  F_Instr, F_PC_plus_4, F_Valid, D_Ready, Flush, KeepSlot,
    output F_Ready, D_Instr, D_PC, D_PC_plus_4, D_Valid, Count
  );

  modport master (
    output F_Instr, F_PC_plus_4, F_Valid, D_Ready, Flush, KeepSlot,
    input  F_Ready, D_Instr, D_PC, D_PC_plus_4, D_Valid, Count
  );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry FIFO between fetch and decode. Absorbs decode stalls and handles
// redirect flushes that may retain exactly one delay-slot word.
module if_id_buffer #(
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic           clk,
  input  logic           reset,
  if_id_buffer_if.slave  bus
);

  logic [1:0][31:0] instr_q, instr_d;
  logic [1:0][31:0] pcp4_q,  pcp4_d;
  logic             head_q,  head_d;
  logic [1:0]       count_q, count_d;

  logic       push;
  logic       pop;
  logic       push_slot;
  logic [1:0] survive_cnt;
  logic [1:0] post_cnt;

  // F_Ready depends only on Count, so a full buffer refuses a word even when
  // decode pops in the same cycle.
  assign push      = bus.F_Valid && (count_q != 2'd2);
  assign pop       = (count_q != 2'd0) && bus.D_Ready;
  assign push_slot = head_q + count_q[0];

  always_comb begin
    instr_d     = instr_q;
    pcp4_d      = pcp4_q;
    head_d      = head_q;
    survive_cnt = count_q - {1'b0, pop};
    post_cnt    = survive_cnt + {1'b0, push};
    count_d     = post_cnt;

    if (push) begin
      instr_d[push_slot] = bus.F_Instr;
      pcp4_d[push_slot]  = bus.F_PC_plus_4;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    // The oldest surviving word always sits at head_d, whether it was already
    // stored or is the word pushed this cycle into an otherwise empty queue.
    if (bus.Flush) begin
      count_d = (bus.KeepSlot && (post_cnt != 2'd0)) ? 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      pcp4_q  <= '0;
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  assign bus.F_Ready     = (count_q != 2'd2);
  assign bus.D_Valid     = (count_q != 2'd0);
  assign bus.Count       = count_q;
  assign bus.D_Instr     = bus.D_Valid ? instr_q[head_q] : 32'h0;
  assign bus.D_PC_plus_4 = bus.D_Valid ? pcp4_q[head_q]  : 32'h0;
  assign bus.D_PC        = bus.D_Valid ? (pcp4_q[head_q] - 32'd4) : 32'h0;

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios plus a randomized run, all checked
// against a queue model of the fetch-to-decode buffer.
module tb_if_id_buffer;
  localparam logic [31:0] PC_BASE = 32'h0000_3000;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  if_id_buffer_if bus ();

  if_id_buffer #(.PC_BASE(PC_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of {instr, pc+4}
  logic [63:0] exp_q[$];

  function automatic logic [1:0] m_count();
    return 2'(exp_q.size());
  endfunction
  function automatic logic m_valid();
    return exp_q.size() != 0;
  endfunction
  function automatic logic m_ready();
    return exp_q.size() < 2;
  endfunction
  function automatic logic [31:0] m_instr();
    return (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0;
  endfunction
  function automatic logic [31:0] m_pcp4();
    return (exp_q.size() != 0) ? exp_q[0][31:0] : 32'h0;
  endfunction
  function automatic logic [31:0] m_pc();
    return (exp_q.size() != 0) ? exp_q[0][31:0] - 32'd4 : 32'h0;
  endfunction

  task automatic model_step(input logic [31:0] instr, input logic [31:0] pcp4,
                            input logic fv, input logic dr, input logic fl, input logic ks);
    logic        rdy;
    logic [63:0] keep_e;
    rdy = (exp_q.size() < 2);
    if (dr && exp_q.size() != 0) void'(exp_q.pop_front());
    if (fv && rdy) exp_q.push_back({instr, pcp4});
    if (fl) begin
      if (ks && exp_q.size() != 0) begin
        keep_e = exp_q[0];
        exp_q.delete();
        exp_q.push_back(keep_e);
      end else begin
        exp_q.delete();
      end
    end
  endtask

  // Driver: apply inputs at the falling edge, clock once, return at the next falling edge
  task automatic cycle(input logic [31:0] instr, input logic [31:0] pcp4,
                       input logic fv, input logic dr, input logic fl, input logic ks);
    bus.F_Instr     = instr;
    bus.F_PC_plus_4 = pcp4;
    bus.F_Valid     = fv;
    bus.D_Ready     = dr;
    bus.Flush       = fl;
    bus.KeepSlot    = ks;
    @(posedge clk);
    model_step(instr, pcp4, fv, dr, fl, ks);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.F_Instr = 32'h0; bus.F_PC_plus_4 = 32'h0; bus.F_Valid = 1'b0;
    bus.D_Ready = 1'b0;  bus.Flush = 1'b0;        bus.KeepSlot = 1'b0;
  endtask

  task automatic test_reset();
    cycle(32'hAAAA_0001, 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'hAAAA_0002, 32'h3008, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.Count !== 2'd2) begin
      errors++; $display("FAIL reset_prefill count: got %0d want 2", bus.Count);
    end
    reset = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (bus.Count !== 2'd0) begin errors++; $display("FAIL reset_async count: got %0d want 0", bus.Count); end
    checks++;
    if (bus.D_Valid !== 1'b0) begin errors++; $display("FAIL reset_async d_valid: got %b want 0", bus.D_Valid); end
    checks++;
    if (bus.D_Instr !== 32'h0) begin errors++; $display("FAIL reset_async d_instr: got %h want 0", bus.D_Instr); end
    checks++;
    if (bus.D_PC !== 32'h0 || bus.D_PC_plus_4 !== 32'h0) begin
      errors++; $display("FAIL reset_async d_pc: got %h/%h want 0/0", bus.D_PC, bus.D_PC_plus_4);
    end
    checks++;
    if (bus.F_Ready !== 1'b1) begin errors++; $display("FAIL reset_async f_ready: got %b want 1", bus.F_Ready); end
    // No push may land while reset is held low
    bus.F_Valid = 1'b1; bus.F_Instr = 32'hDEAD_BEEF; bus.F_PC_plus_4 = 32'h3004;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.Count !== 2'd0) begin errors++; $display("FAIL reset_held count: got %0d want 0", bus.Count); end
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_streaming();
    cycle(32'h3c01_0000, 32'h3004, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.D_Instr !== 32'h3c01_0000 || bus.D_PC !== 32'h3000 || bus.Count !== 2'd1) begin
      errors++; $display("FAIL stream_1: got instr=%h pc=%h cnt=%0d want 3c010000/3000/1",
                         bus.D_Instr, bus.D_PC, bus.Count);
    end
    cycle(32'h3421_0001, 32'h3008, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.D_Instr !== 32'h3421_0001 || bus.D_PC !== 32'h3004 || bus.Count !== 2'd1) begin
      errors++; $display("FAIL stream_2: got instr=%h pc=%h cnt=%0d want 34210001/3004/1",
                         bus.D_Instr, bus.D_PC, bus.Count);
    end
    // Empty with decode ready: the last word drains, then nothing underflows
    cycle(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.Count !== 2'd0 || bus.D_Valid !== 1'b0 || bus.D_Instr !== 32'h0) begin
      errors++; $display("FAIL empty_pop: got cnt=%0d valid=%b instr=%h want 0/0/0",
                         bus.Count, bus.D_Valid, bus.D_Instr);
    end
  endtask

  task automatic test_full();
    cycle(32'h1111_0001, 32'h3004, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'h1111_0002, 32'h3008, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.F_Ready !== 1'b0 || bus.Count !== 2'd2) begin
      errors++; $display("FAIL full_ready: got rdy=%b cnt=%0d want 0/2", bus.F_Ready, bus.Count);
    end
    cycle(32'h1111_0003, 32'h300C, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.Count !== 2'd2 || bus.D_PC_plus_4 !== 32'h3004) begin
      errors++; $display("FAIL full_reject: got cnt=%0d pcp4=%h want 2/3004", bus.Count, bus.D_PC_plus_4);
    end
    cycle(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.D_PC !== 32'h3004 || bus.D_Instr !== 32'h1111_0002 || bus.F_Ready !== 1'b1 || bus.Count !== 2'd1) begin
      errors++; $display("FAIL full_release: got pc=%h instr=%h rdy=%b cnt=%0d want 3004/11110002/1/1",
                         bus.D_PC, bus.D_Instr, bus.F_Ready, bus.Count);
    end
  endtask

  task automatic test_flush_drop();
    cycle(32'h2222_0003, 32'h300C, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'h2222_0004, 32'h3010, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.Count !== 2'd0 || bus.D_Valid !== 1'b0 || bus.D_Instr !== 32'h0) begin
      errors++; $display("FAIL flush_drop: got cnt=%0d valid=%b instr=%h want 0/0/0",
                         bus.Count, bus.D_Valid, bus.D_Instr);
    end
  endtask

  task automatic test_delay_slot();
    cycle(32'h1000_0010, 32'h3008, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'h3333_0001, 32'h300C, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.Count !== 2'd1 || bus.D_PC_plus_4 !== 32'h300C || bus.D_PC !== 32'h3008 ||
        bus.D_Instr !== 32'h3333_0001) begin
      errors++; $display("FAIL delay_slot: got cnt=%0d pcp4=%h pc=%h instr=%h want 1/300c/3008/33330001",
                         bus.Count, bus.D_PC_plus_4, bus.D_PC, bus.D_Instr);
    end
  endtask

  task automatic test_slot_arriving();
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(32'h1000_0020, 32'h3014, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(32'h4444_0001, 32'h3018, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.Count !== 2'd1 || bus.D_PC_plus_4 !== 32'h3018 || bus.D_Instr !== 32'h4444_0001) begin
      errors++; $display("FAIL slot_arriving: got cnt=%0d pcp4=%h instr=%h want 1/3018/44440001",
                         bus.Count, bus.D_PC_plus_4, bus.D_Instr);
    end
    // Flush into empty with KeepSlot keeps the incoming word; PC+4 of 0 wraps
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(32'h5555_0001, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.Count !== 2'd1 || bus.D_PC !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL pc_wrap: got cnt=%0d pc=%h want 1/fffffffc", bus.Count, bus.D_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        fv, dr, fl, ks;
    pcp4 = PC_BASE;
    for (int i = 0; i < 400; i++) begin
      instr = $urandom;
      fv    = ($urandom_range(0, 3) != 0);
      dr    = ($urandom_range(0, 2) != 0);
      fl    = ($urandom_range(0, 9) == 0);
      ks    = $urandom_range(0, 1) == 1;
      if (fv && m_ready()) pcp4 = pcp4 + 32'd4;
      cycle(instr, pcp4, fv, dr, fl, ks);
      checks++;
      if (bus.Count !== m_count() || bus.D_Valid !== m_valid() || bus.F_Ready !== m_ready() ||
          bus.D_Instr !== m_instr() || bus.D_PC_plus_4 !== m_pcp4() || bus.D_PC !== m_pc()) begin
        errors++;
        $display("FAIL random[%0d]: got cnt=%0d v=%b r=%b i=%h p4=%h pc=%h want cnt=%0d v=%b r=%b i=%h p4=%h pc=%h",
                 i, bus.Count, bus.D_Valid, bus.F_Ready, bus.D_Instr, bus.D_PC_plus_4, bus.D_PC,
                 m_count(), m_valid(), m_ready(), m_instr(), m_pcp4(), m_pc());
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Count !== 2'd0 || bus.D_Valid !== 1'b0 || bus.F_Ready !== 1'b1) begin
      errors++; $display("FAIL post_reset: got cnt=%0d valid=%b rdy=%b want 0/0/1",
                         bus.Count, bus.D_Valid, bus.F_Ready);
    end
    test_reset();
    test_streaming();
    test_full();
    test_flush_drop();
    test_delay_slot();
    test_slot_arriving();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
